mem_copy_engine: RTL and testbench

- Sequential initiator that drives the single-port read/write interface of the team's banked sequential memory (combinational read on RA; write on clock edge when WE=1).
- Copies a block of len words from source address src to destination address dst inside that memory, one word every two cycles.
- Uses a start/busy/done handshake.
- Sits between a control unit and one memSequential instance. The engine's mem* outputs connect directly to the memory's A/WD/WE, and memRA connects to RA.

---
 rtl/mem_pkg.sv | 14 +
 rtl/memSequential.sv | 28 ++
 rtl/mem_copy_engine.sv | 91 +++++++++
 tb/tb_mem_copy_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the sequential memory and the copy engine that drives it.
package mem_pkg;

    localparam int MEM_M = 8;
    localparam int MEM_K = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copyState_t;

endpackage

// File: rtl/memSequential.sv
// Two-bank sequential memory: combinational read on RA, write on the rising clock edge when WE=1.
module memSequential
    import mem_pkg::*;
#(
    parameter int M = MEM_M,
    parameter int K = MEM_K
) (
    input  logic         clock,
    input  logic [K-1:0] A,
    input  logic [M-1:0] WD,
    input  logic         WE,
    output logic [M-1:0] RA
);

    logic [M-1:0] module1 [2**(K-1)];
    logic [M-1:0] module2 [2**(K-1)];

    // The address MSB picks the bank; the remaining bits index within it.
    always_ff @(posedge clock) begin
        if (WE) begin
            if (A[K-1]) module2[A[K-2:0]] <= WD;
            else        module1[A[K-2:0]] <= WD;
        end
    end

    assign RA = A[K-1] ? module2[A[K-2:0]] : module1[A[K-2:0]];

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy engine: moves len words from src to dst, one READ and one WRITE cycle per word.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int M = MEM_M,
    parameter int K = MEM_K
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [K-1:0] src,
    input  logic [K-1:0] dst,
    input  logic [K:0]   len,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] memA,
    output logic [M-1:0] memWD,
    output logic         memWE,
    input  logic [M-1:0] memRA
);

    copyState_t   state, nextState;
    logic [K-1:0] curSrc, curDst;
    logic [K:0]   remaining;
    logic [M-1:0] dataBuf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  if (start) nextState = (len == '0) ? DONE : READ;
            READ:  nextState = WRITE;
            WRITE: nextState = (remaining == (K+1)'(1)) ? DONE : READ;
            DONE:  nextState = IDLE;
        endcase
    end

    // Address counters wrap modulo 2^K; remaining is one bit wider so a full-memory copy fits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            curSrc    <= '0;
            curDst    <= '0;
            remaining <= '0;
            dataBuf   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        curSrc    <= src;
                        curDst    <= dst;
                        remaining <= len;
                    end
                end
                READ:  dataBuf <= memRA;
                WRITE: begin
                    curSrc    <= curSrc + K'(1);
                    curDst    <= curDst + K'(1);
                    remaining <= remaining - (K+1)'(1);
                end
                DONE: ;
            endcase
        end
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        memA  = '0;
        memWD = '0;
        memWE = 1'b0;
        unique case (state)
            IDLE: ;
            READ: begin
                busy = 1'b1;
                memA = curSrc;
            end
            WRITE: begin
                busy  = 1'b1;
                memA  = curDst;
                memWD = dataBuf;
                memWE = 1'b1;
            end
            DONE: done = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine driving a memSequential instance.
module tb_mem_copy_engine;
    import mem_pkg::*;

    localparam int M = 8;
    localparam int K = 11;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [K-1:0] src, dst;
    logic [K:0]   len;
    logic         busy, done, engWE;
    logic [K-1:0] engA;
    logic [M-1:0] engWD, ra;

    logic         tbOwn;
    logic [K-1:0] tbA;
    logic [M-1:0] tbWD;
    logic         tbWE;
    logic [K-1:0] muxA;
    logic [M-1:0] muxWD;
    logic         muxWE;

    int checks = 0;
    int errors = 0;

    int           busyCnt, doneCnt, doneCyc, weCnt;
    logic [K-1:0] wrAddr [16];
    logic [M-1:0] wrData [16];
    logic         snapBusy, snapDone, snapWE;

    mem_copy_engine #(.M(M), .K(K)) dut (
        .clock(clock), .reset(reset), .start(start),
        .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done),
        .memA(engA), .memWD(engWD), .memWE(engWE), .memRA(ra)
    );

    memSequential #(.M(M), .K(K)) mem (
        .clock(clock), .A(muxA), .WD(muxWD), .WE(muxWE), .RA(ra)
    );

    // The bench borrows the memory port for preload and readback while the engine is idle.
    assign muxA  = tbOwn ? tbA  : engA;
    assign muxWD = tbOwn ? tbWD : engWD;
    assign muxWE = tbOwn ? tbWE : engWE;

    always #5 clock = ~clock;

    task automatic memWrite(input logic [K-1:0] a, input logic [M-1:0] v);
        @(negedge clock);
        tbOwn = 1'b1; tbA = a; tbWD = v; tbWE = 1'b1;
        @(posedge clock);
        #1 tbWE = 1'b0;
    endtask

    task automatic memRead(input logic [K-1:0] a, output logic [M-1:0] v);
        tbOwn = 1'b1; tbWE = 1'b0; tbA = a;
        #1 v = ra;
    endtask

    // Starts a job and records per-cycle activity; pulseAt/resetAt of -1 disable those events.
    task automatic runJob(input logic [K-1:0] s, input logic [K-1:0] d, input logic [K:0] n,
                          input int pulseAt, input int resetAt, input int cycles);
        @(negedge clock);
        tbOwn = 1'b0; src = s; dst = d; len = n; start = 1'b1;
        busyCnt = 0; doneCnt = 0; doneCyc = -1; weCnt = 0;
        @(posedge clock);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= cycles; cyc++) begin
            @(negedge clock);
            start = (cyc == pulseAt);
            if (cyc == pulseAt) begin
                src = 11'h700; dst = 11'h710; len = 12'd2;
            end
            if (cyc == resetAt + 1) reset = 1'b0;
            if (cyc == resetAt) begin
                reset = 1'b1;
                #1;
                snapBusy = busy; snapDone = done; snapWE = engWE;
            end
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (engWE) begin
                if (weCnt < 16) begin
                    wrAddr[weCnt] = engA;
                    wrData[weCnt] = engWD;
                end
                weCnt++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        tbOwn = 1'b1; tbA = '0; tbWD = '0; tbWE = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (engWE !== 1'b0) begin errors++; $display("[TB] FAIL reset_memWE got %b want 0", engWE); end
        checks++; if (engA !== 11'h000) begin errors++; $display("[TB] FAIL reset_memA got %h want 000", engA); end
        checks++; if (engWD !== 8'h00) begin errors++; $display("[TB] FAIL reset_memWD got %h want 00", engWD); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [M-1:0] expv [4];
        logic [M-1:0] v;
        expv[0] = 8'hA1; expv[1] = 8'hB2; expv[2] = 8'hC3; expv[3] = 8'hD4;
        for (int i = 0; i < 4; i++) memWrite(11'h010 + 11'(i), expv[i]);
        runJob(11'h010, 11'h020, 12'd4, -1, -1, 12);
        checks++; if (busyCnt != 8) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want 8", busyCnt); end
        checks++; if (doneCyc != 9) begin errors++; $display("[TB] FAIL basic_done_cycle got %0d want 9", doneCyc); end
        checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL basic_done_count got %0d want 1", doneCnt); end
        checks++; if (weCnt != 4) begin errors++; $display("[TB] FAIL basic_write_count got %0d want 4", weCnt); end
        for (int i = 0; i < 4; i++) begin
            memRead(11'h020 + 11'(i), v);
            checks++; if (v !== expv[i]) begin errors++; $display("[TB] FAIL basic_dst[%0d] got %h want %h", i, v, expv[i]); end
            memRead(11'h010 + 11'(i), v);
            checks++; if (v !== expv[i]) begin errors++; $display("[TB] FAIL basic_src[%0d] got %h want %h", i, v, expv[i]); end
        end
    endtask

    task automatic test_bank_cross();
        logic [M-1:0] expv [4];
        logic [M-1:0] v;
        expv[0] = 8'h11; expv[1] = 8'h22; expv[2] = 8'h33; expv[3] = 8'h44;
        for (int i = 0; i < 4; i++) memWrite(11'h3FE + 11'(i), expv[i]);
        runJob(11'h3FE, 11'h500, 12'd4, -1, -1, 12);
        for (int i = 0; i < 4; i++) begin
            memRead(11'h500 + 11'(i), v);
            checks++; if (v !== expv[i]) begin errors++; $display("[TB] FAIL bank_dst[%0d] got %h want %h", i, v, expv[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [K-1:0] expA [4];
        logic [M-1:0] expv [4];
        logic [M-1:0] v;
        expA[0] = 11'h7FE; expA[1] = 11'h7FF; expA[2] = 11'h000; expA[3] = 11'h001;
        expv[0] = 8'h91; expv[1] = 8'h92; expv[2] = 8'h93; expv[3] = 8'h94;
        for (int i = 0; i < 4; i++) memWrite(11'h100 + 11'(i), expv[i]);
        runJob(11'h100, 11'h7FE, 12'd4, -1, -1, 12);
        checks++; if (weCnt != 4) begin errors++; $display("[TB] FAIL wrap_write_count got %0d want 4", weCnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wrAddr[i] !== expA[i]) begin errors++; $display("[TB] FAIL wrap_addr[%0d] got %h want %h", i, wrAddr[i], expA[i]); end
            checks++; if (wrData[i] !== expv[i]) begin errors++; $display("[TB] FAIL wrap_wdata[%0d] got %h want %h", i, wrData[i], expv[i]); end
            memRead(expA[i], v);
            checks++; if (v !== expv[i]) begin errors++; $display("[TB] FAIL wrap_dst[%0d] got %h want %h", i, v, expv[i]); end
        end
    endtask

    task automatic test_zero_len();
        runJob(11'h040, 11'h050, 12'd0, -1, -1, 5);
        checks++; if (doneCyc != 1) begin errors++; $display("[TB] FAIL zero_done_cycle got %0d want 1", doneCyc); end
        checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL zero_done_count got %0d want 1", doneCnt); end
        checks++; if (busyCnt != 0) begin errors++; $display("[TB] FAIL zero_busy_cycles got %0d want 0", busyCnt); end
        checks++; if (weCnt != 0) begin errors++; $display("[TB] FAIL zero_write_count got %0d want 0", weCnt); end
    endtask

    task automatic test_overlap();
        logic [M-1:0] v;
        for (int i = 0; i < 4; i++) memWrite(11'h100 + 11'(i), 8'(5 + i));
        runJob(11'h100, 11'h101, 12'd3, -1, -1, 10);
        for (int i = 0; i < 4; i++) begin
            memRead(11'h100 + 11'(i), v);
            checks++; if (v !== 8'h05) begin errors++; $display("[TB] FAIL overlap[%0d] got %h want 05", i, v); end
        end
    endtask

    task automatic test_ignore_start();
        logic [M-1:0] v;
        for (int i = 0; i < 4; i++) memWrite(11'h180 + 11'(i), 8'(8'h71 + i));
        memWrite(11'h710, 8'h5A);
        runJob(11'h180, 11'h190, 12'd4, 2, -1, 14);
        checks++; if (weCnt != 4) begin errors++; $display("[TB] FAIL ignore_write_count got %0d want 4", weCnt); end
        checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL ignore_done_count got %0d want 1", doneCnt); end
        checks++; if (busyCnt != 8) begin errors++; $display("[TB] FAIL ignore_busy_cycles got %0d want 8", busyCnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wrAddr[i] !== 11'h190 + 11'(i)) begin errors++; $display("[TB] FAIL ignore_addr[%0d] got %h want %h", i, wrAddr[i], 11'h190 + 11'(i)); end
        end
        memRead(11'h710, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("[TB] FAIL ignore_stray_dst got %h want 5a", v); end
    endtask

    task automatic test_reset_mid();
        logic [M-1:0] expv [4];
        logic [M-1:0] v;
        for (int i = 0; i < 4; i++) begin
            memWrite(11'h200 + 11'(i), 8'(8'h61 + i));
            memWrite(11'h300 + 11'(i), 8'hEE);
        end
        expv[0] = 8'h61; expv[1] = 8'h62; expv[2] = 8'hEE; expv[3] = 8'hEE;
        runJob(11'h200, 11'h300, 12'd4, -1, 6, 14);
        checks++; if (snapWE !== 1'b0) begin errors++; $display("[TB] FAIL midreset_memWE got %b want 0", snapWE); end
        checks++; if (snapBusy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", snapBusy); end
        checks++; if (snapDone !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %b want 0", snapDone); end
        checks++; if (weCnt != 2) begin errors++; $display("[TB] FAIL midreset_write_count got %0d want 2", weCnt); end
        checks++; if (doneCnt != 0) begin errors++; $display("[TB] FAIL midreset_done_count got %0d want 0", doneCnt); end
        for (int i = 0; i < 4; i++) begin
            memRead(11'h300 + 11'(i), v);
            checks++; if (v !== expv[i]) begin errors++; $display("[TB] FAIL midreset_dst[%0d] got %h want %h", i, v, expv[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bank_cross();
        test_wrap();
        test_zero_len();
        test_overlap();
        test_ignore_start();
        test_reset_mid();
        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
